basys3_input_conditioner: RTL and testbench

Conditions the Basys3 push-buttons and slide switches for the 8-bit CPU top level. It synchronises, debounces and edge-detects all 21 raw inputs, and drives a run/single-step controller that produces the CPU clock-enable. It sits directly upstream of the CPU top level and replaces the ad-hoc `debounce_clock` sampling there. Its outputs feed `control_unit` enable/stepping and the LED/seven-segment logic.

---
 rtl/basys3_io_pkg.sv | 18 +
 rtl/debounce_cell.sv | 62 ++++++
 rtl/basys3_input_conditioner.sv | 135 +++++++++++++
 tb/tb_basys3_input_conditioner.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/basys3_io_pkg.sv
// Shared constants and types for the Basys3 button/switch conditioner.
// Button indices follow the {btnC, btnU, btnR, btnD, btnL} bit order.
package basys3_io_pkg;

    localparam int BTN_L = 0;
    localparam int BTN_D = 1;
    localparam int BTN_R = 2;
    localparam int BTN_U = 3;
    localparam int BTN_C = 4;

    localparam int DB_CNT_W = 4;

    typedef enum logic {
        HALT = 1'b0,
        RUN  = 1'b1
    } ctrl_state_t;

endpackage

// File: rtl/debounce_cell.sv
// One-bit 2-flop synchroniser plus tick-sampled debouncer; level flips on the
// STABLE_SAMPLES-th disagreeing tick, rise pulses in that same cycle; no backpressure.
module debounce_cell
    import basys3_io_pkg::*;
#(
    parameter int STABLE_SAMPLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    input  logic tick,
    output logic level,
    output logic rise
);

    logic                sync1_q, sync1_d;
    logic                sync2_q, sync2_d;
    logic [DB_CNT_W-1:0] cnt_q, cnt_d;
    logic [DB_CNT_W-1:0] cnt_inc;
    logic                level_q, level_d;
    logic                rise_q, rise_d;

    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        cnt_inc = cnt_q + DB_CNT_W'(1);
        if (tick) begin
            if (sync2_q == level_q) begin
                cnt_d = '0;
            end else if (cnt_inc == DB_CNT_W'(STABLE_SAMPLES)) begin
                cnt_d   = '0;
                level_d = ~level_q;
                rise_d  = ~level_q;
            end else begin
                cnt_d = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/basys3_input_conditioner.sv
// Debounces 5 buttons + 16 switches and, with INPUT_COND_STEP_CTRL_EN, runs a HALT/RUN
// step controller for cpu_en (step 1 cycle after btnC press); all outputs registered, no backpressure.
module basys3_input_conditioner
    import basys3_io_pkg::*;
#(
    parameter int SAMPLE_DIV     = 100000,
    parameter int STABLE_SAMPLES = 4,
    parameter int RUN_DIV        = 16777216
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  btn,
    input  logic [15:0] sw,
    output logic [4:0]  btn_level,
    output logic [4:0]  btn_press,
    output logic [15:0] sw_level,
    output logic        cpu_en,
    output logic        run_mode
);

    localparam int SMP_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    logic [SMP_W-1:0] smp_cnt_q, smp_cnt_d;
    logic             tick;

    assign tick = (smp_cnt_q == SMP_W'(SAMPLE_DIV - 1));

    always_comb begin
        smp_cnt_d = tick ? '0 : smp_cnt_q + SMP_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp_cnt_q <= '0;
        end else begin
            smp_cnt_q <= smp_cnt_d;
        end
    end

    for (genvar i = 0; i < 5; i++) begin : g_btn
        debounce_cell #(.STABLE_SAMPLES(STABLE_SAMPLES)) u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .din   (btn[i]),
            .tick  (tick),
            .level (btn_level[i]),
            .rise  (btn_press[i])
        );
    end

    // Switches share the cell but nothing downstream wants their edges.
    for (genvar i = 0; i < 16; i++) begin : g_sw
        debounce_cell #(.STABLE_SAMPLES(STABLE_SAMPLES)) u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .din   (sw[i]),
            .tick  (tick),
            .level (sw_level[i]),
            .rise  ()
        );
    end

`ifdef INPUT_COND_STEP_CTRL_EN

    localparam int RUN_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;

    ctrl_state_t      state_q, state_d;
    logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
    logic             cpu_en_q, cpu_en_d;

    // btnU outranks btnC, and a leaving-RUN press swallows any due pulse.
    always_comb begin
        state_d   = state_q;
        run_cnt_d = '0;
        cpu_en_d  = 1'b0;
        case (state_q)
            HALT: begin
                if (btn_press[BTN_U]) begin
                    state_d = RUN;
                end else if (btn_press[BTN_C]) begin
                    cpu_en_d = 1'b1;
                end
            end
            RUN: begin
                if (run_cnt_q == RUN_W'(RUN_DIV - 1)) begin
                    run_cnt_d = '0;
                    cpu_en_d  = ~btn_press[BTN_U];
                end else begin
                    run_cnt_d = run_cnt_q + RUN_W'(1);
                end
                if (btn_press[BTN_U]) begin
                    state_d = HALT;
                end
            end
            default: state_d = HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= HALT;
            run_cnt_q <= '0;
            cpu_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_cnt_q <= run_cnt_d;
            cpu_en_q  <= cpu_en_d;
        end
    end

    assign cpu_en   = cpu_en_q;
    assign run_mode = (state_q == RUN);

`else

    logic cpu_en_q, cpu_en_d;

    always_comb begin
        cpu_en_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_en_q <= 1'b0;
        end else begin
            cpu_en_q <= cpu_en_d;
        end
    end

    assign cpu_en   = cpu_en_q;
    assign run_mode = 1'b1;

`endif

endmodule

// File: tb/tb_basys3_input_conditioner.sv
// Directed bench for basys3_input_conditioner with SAMPLE_DIV=4, STABLE_SAMPLES=3, RUN_DIV=10.
// Edge numbers count posedges after reset release; sample ticks land on edges 4, 8, 12, ...
module tb_basys3_input_conditioner;

`ifdef INPUT_COND_STEP_CTRL_EN
    localparam bit CTRL = 1'b1;
`else
    localparam bit CTRL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  btn;
    logic [15:0] sw;
    logic [4:0]  btn_level;
    logic [4:0]  btn_press;
    logic [15:0] sw_level;
    logic        cpu_en;
    logic        run_mode;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_n   = 0;

    basys3_input_conditioner #(
        .SAMPLE_DIV     (4),
        .STABLE_SAMPLES (3),
        .RUN_DIV        (10)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn       (btn),
        .sw        (sw),
        .btn_level (btn_level),
        .btn_press (btn_press),
        .sw_level  (sw_level),
        .cpu_en    (cpu_en),
        .run_mode  (run_mode)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got=%0h expected=%0h", tag, edge_n, got, exp);
        end
    endtask

    task automatic adv_to(input int n);
        while (edge_n < n) begin
            @(posedge clk);
            edge_n++;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        edge_n = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst_n = 1'b0;
        btn   = '0;
        sw    = '0;

        // Reset state and clean btnC press
        do_reset();
        check("rst_btn_level", btn_level, 5'h00);
        check("rst_btn_press", btn_press, 5'h00);
        check("rst_sw_level", sw_level, 16'h0000);
        check("rst_cpu_en", cpu_en, 1'b0);
        check("rst_run_mode", run_mode, CTRL ? 1'b0 : 1'b1);
        btn[4] = 1'b1;
        adv_to(11);
        check("press_pre_level", btn_level, 5'h00);
        adv_to(12);
        check("press_level", btn_level, 5'h10);
        check("press_pulse", btn_press, 5'h10);
        adv_to(13);
        check("press_pulse_end", btn_press, 5'h00);
        check("step_cpu_en", cpu_en, 1'b1);
        adv_to(14);
        check("step_cpu_en_end", cpu_en, CTRL ? 1'b0 : 1'b1);
        btn[4] = 1'b0;
        adv_to(27);
        check("release_pre_level", btn_level, 5'h10);
        adv_to(28);
        check("release_level", btn_level, 5'h00);
        check("release_no_press", btn_press, 5'h00);
        adv_to(29);
        check("release_no_step", cpu_en, CTRL ? 1'b0 : 1'b1);

        // Bounce rejection on sw[7]
        do_reset();
        seen  = 1'b0;
        sw[7] = 1'b1;
        for (int e = 1; e <= 51; e++) begin
            adv_to(e);
            if (sw_level[7]) seen = 1'b1;
            if (e < 40 && e % 5 == 0) sw[7] = ~sw[7];
            else if (e == 40) sw[7] = 1'b1;
        end
        check("bounce_hold_low", seen, 1'b0);
        adv_to(52);
        check("bounce_settle", sw_level, 16'h0080);
        check("bounce_no_press", btn_press, 5'h00);

        // Reset in the middle of a debounce
        do_reset();
        sw = 16'h8000;
        adv_to(12);
        check("mid_sw_level", sw_level, 16'h8000);
        adv_to(13);
        btn[0] = 1'b1;
        adv_to(21);
        check("mid_pending", btn_level, 5'h00);
        rst_n = 1'b0;
        #1;
        check("mid_rst_btn_level", btn_level, 5'h00);
        check("mid_rst_sw_level", sw_level, 16'h0000);
        check("mid_rst_press", btn_press, 5'h00);
        check("mid_rst_cpu_en", cpu_en, 1'b0);
        check("mid_rst_run_mode", run_mode, CTRL ? 1'b0 : 1'b1);
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        edge_n = 0;
        adv_to(8);
        check("fresh_after_2", btn_level, 5'h00);
        adv_to(11);
        check("fresh_before_3", btn_level, 5'h00);
        adv_to(12);
        check("fresh_level", btn_level, 5'h01);
        check("fresh_press", btn_press, 5'h01);
        check("fresh_sw_level", sw_level, 16'h8000);
        btn = '0;
        sw  = '0;

`ifdef INPUT_COND_STEP_CTRL_EN
        // RUN mode: pulses at +10/+20/+30, btnC ignored, exit suppresses due pulse
        do_reset();
        btn[3] = 1'b1;
        adv_to(12);
        check("run_press_u", btn_press, 5'h08);
        check("run_pre_mode", run_mode, 1'b0);
        for (int e = 13; e <= 45; e++) begin
            adv_to(e);
            check("run_cpu_en", cpu_en, (e == 23 || e == 33 || e == 43) ? 1'b1 : 1'b0);
            check("run_mode_on", run_mode, 1'b1);
            if (e == 28) check("run_press_c", btn_press, 5'h10);
            if (e == 14) btn[4] = 1'b1;
        end
        btn[3] = 1'b0;
        for (int e = 46; e <= 80; e++) begin
            adv_to(e);
            check("exit_cpu_en", cpu_en, (e == 53 || e == 63) ? 1'b1 : 1'b0);
            check("exit_run_mode", run_mode, (e <= 72) ? 1'b1 : 1'b0);
            if (e == 60) btn[3] = 1'b1;
        end
        btn = '0;

        // Simultaneous btnC + btnU
        do_reset();
        btn = 5'h18;
        adv_to(12);
        check("simul_press", btn_press, 5'h18);
        adv_to(13);
        check("simul_run_mode", run_mode, 1'b1);
        check("simul_no_step", cpu_en, 1'b0);
        adv_to(22);
        check("simul_quiet", cpu_en, 1'b0);
        adv_to(23);
        check("simul_first_run", cpu_en, 1'b1);
        btn = '0;
`else
        // Free-running CPU enable
        do_reset();
        check("free_rst_cpu_en", cpu_en, 1'b0);
        check("free_rst_run_mode", run_mode, 1'b1);
        btn = 5'h18;
        for (int e = 1; e <= 20; e++) begin
            adv_to(e);
            check("free_run", {run_mode, cpu_en}, 2'b11);
        end
        btn = '0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
